mac_engine: RTL

Parametrised signed multiply-accumulate engine for the audio datapath. It is the next-generation replacement for the fixed 16x16 unsigned accumulator. It accepts a stream of operand pairs over a valid/ready handshake and accumulates their products per vector, with the vector delimited by a `last` flag. At the end of each vector it emits one rounded, saturated result through an output register with backpressure. It sits between the sample/coefficient fetch logic and the output sample formatter.

---
 rtl/mac_pkg.sv | 24 ++
 rtl/mac_round_sat.sv | 47 ++++
 rtl/mac_engine.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, result record and parameter check for mac_engine
package mac_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_ACC_W  = 40;
    localparam int DEF_OUT_W  = 16;
    localparam int DEF_SHIFT  = 15;

    // Widest result the record can carry; narrower results are sign-extended into it.
    localparam int MAX_OUT_W  = 64;

    typedef struct packed {
        logic [MAX_OUT_W-1:0] data;
        logic                 sat;
        logic                 ovf;
    } mac_result_t;

    // True when the accumulator can hold at least one full-width product.
    function automatic logic acc_w_ok(input int acc_w, input int data_w, input int coef_w);
        return acc_w >= data_w + coef_w;
    endfunction

endpackage

// File: rtl/mac_round_sat.sv
// rtl/mac_round_sat.sv - combinational half-up rounding, arithmetic shift and saturation
//   i_acc  : signed accumulator value (ACC_W)
//   o_data : rounded, clipped result (OUT_W)
//   o_sat  : o_data was clipped
module mac_round_sat #(
    parameter int ACC_W = 40,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [OUT_W-1:0] o_data,
    output logic                    o_sat
);
    // One guard bit so the rounding add cannot wrap.
    localparam int EXT_W   = ACC_W + 1;
    // Compare at a width that holds both the shifted value and the output range.
    localparam int CMP_W   = ((EXT_W > OUT_W) ? EXT_W : OUT_W) + 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EXT_W-1:0] RND  = (SHIFT > 0) ? (EXT_W'(1) << RND_POS) : '0;
    localparam logic signed [CMP_W-1:0] MAXV = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] MINV = ~MAXV;

    logic signed [EXT_W-1:0] w_ext;
    logic signed [EXT_W-1:0] w_sum;
    logic signed [EXT_W-1:0] w_shr;
    logic signed [CMP_W-1:0] w_wide;
    logic signed [CMP_W-1:0] w_clip;
    logic                    w_over;
    logic                    w_under;
    logic                    w_unused_hi;

    assign w_ext   = EXT_W'(i_acc);
    assign w_sum   = w_ext + RND;
    assign w_shr   = w_sum >>> SHIFT;
    assign w_wide  = CMP_W'(w_shr);
    assign w_over  = w_wide > MAXV;
    assign w_under = w_wide < MINV;
    assign w_clip  = w_over ? MAXV : (w_under ? MINV : w_wide);

    assign o_data  = w_clip[OUT_W-1:0];
    assign o_sat   = w_over | w_under;

    // Upper bits are only sign copies once clipped.
    assign w_unused_hi = ^w_clip[CMP_W-1:OUT_W];

endmodule

// File: rtl/mac_engine.sv
// rtl/mac_engine.sv - pipelined signed multiply-accumulate with rounded, saturated vector results
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last : operand beat handshake, last marks end of vector
//   out_valid/out_ready/out_data/out_sat/out_ovf : result handshake with clip and wrap flags
module mac_engine
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int SHIFT  = DEF_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [COEF_W-1:0] in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [OUT_W-1:0]  out_data,
    output logic                     out_sat,
    output logic                     out_ovf
);
    localparam int PROD_W = DATA_W + COEF_W;

    generate
        if (!acc_w_ok(ACC_W, DATA_W, COEF_W)) begin : g_bad_acc_w
            $error("mac_engine: ACC_W must be at least DATA_W+COEF_W");
        end
        if (OUT_W > MAX_OUT_W || OUT_W < 2) begin : g_bad_out_w
            $error("mac_engine: OUT_W out of range");
        end
    endgenerate

    // S1: product stage
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_v1;
    logic                     r_last1;
    logic                     r_first1;
    logic                     r_first;

    // S2: accumulate stage
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovf_acc;
    logic                     r_v2;
    logic                     r_last2;

    // Output register
    mac_result_t              r_res;
    logic                     r_out_valid;

    logic                     w_stall;
    logic                     w_accept;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic                     w_ovf_step;
    logic                     w_ovf_next;
    logic                     w_s2_fire;
    logic                     w_load;
    logic        [OUT_W-1:0]  w_rs_data;
    logic                     w_rs_sat;
    logic                     w_unused_res;

    // A held result freezes the whole pipe, so nothing behind it can overwrite it.
    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod   <= '0;
            r_v1     <= 1'b0;
            r_last1  <= 1'b0;
            r_first1 <= 1'b0;
            r_first  <= 1'b1;
        end else if (!w_stall) begin
            r_prod   <= in_a * in_b;
            r_v1     <= in_valid;
            r_last1  <= in_last;
            r_first1 <= r_first;
            if (w_accept) begin
                r_first <= in_last;
            end
        end
    end

    assign w_prod_ext = ACC_W'(r_prod);
    assign w_base     = r_first1 ? '0 : r_acc;
    assign w_acc_next = w_base + w_prod_ext;
    assign w_ovf_step = (w_base[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                        (w_acc_next[ACC_W-1] != w_base[ACC_W-1]);
    // The first beat of a vector starts a fresh sticky flag.
    assign w_ovf_next = (r_first1 ? 1'b0 : r_ovf_acc) | w_ovf_step;
    assign w_s2_fire  = r_v1 && !w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_v2      <= 1'b0;
            r_last2   <= 1'b0;
        end else if (!w_stall) begin
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            if (w_s2_fire) begin
                r_acc     <= w_acc_next;
                r_ovf_acc <= w_ovf_next;
            end
        end
    end

    // Rounds the completed vector sum held in r_acc.
    mac_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .i_acc  (r_acc),
        .o_data (w_rs_data),
        .o_sat  (w_rs_sat)
    );

    assign w_load = r_v2 && r_last2 && !w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_res       <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_res       <= '{data: MAX_OUT_W'($signed(w_rs_data)), sat: w_rs_sat, ovf: r_ovf_acc};
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_data     = r_res.data[OUT_W-1:0];
    assign out_sat      = r_res.sat;
    assign out_ovf      = r_res.ovf;
    assign w_unused_res = ^r_res.data;

endmodule
